list_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one `list` instance (same DATA_WIDTH/LENGTH) between NUM_REQ independent requesters.
- Accepts one command at a time and drives the list's op interface with a single-cycle op_en.
- Holds the command payload stable for the whole operation.
- Routes every result beat (including FIND_ALL intermediate hits) back to the owning requester.

---
 rtl/list_arbiter_if.sv | 29 ++
 rtl/list_arbiter.sv | 170 +++++++++++++++++
 tb/tb_list_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/list_arbiter_if.sv
// Requester-side bus of list_arbiter: per-requester command slices in, one-hot
// grant and result beats out.
interface list_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LENGTH     = 8
);
  localparam int unsigned LENGTH_WIDTH = $clog2(LENGTH);

  logic [NUM_REQ-1:0]              req;
  logic [3*NUM_REQ-1:0]            req_op_sel;
  logic [DATA_WIDTH*NUM_REQ-1:0]   req_data;
  logic [LENGTH_WIDTH*NUM_REQ-1:0] req_index;
  logic [NUM_REQ-1:0]              gnt;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic                            rsp_last;
  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] rsp_data;
  logic                            rsp_error;

  modport master (
    output req, req_op_sel, req_data, req_index,
    input  gnt, rsp_valid, rsp_last, rsp_data, rsp_error
  );

  modport slave (
    input  req, req_op_sel, req_data, req_index,
    output gnt, rsp_valid, rsp_last, rsp_data, rsp_error
  );
endinterface

// File: rtl/list_arbiter.sv
// Round-robin arbiter sharing one list instance between NUM_REQ requesters; one
// command in flight, result beats routed back to the owner.
module list_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LENGTH     = 8,
  localparam int unsigned LENGTH_WIDTH = $clog2(LENGTH),
  localparam int unsigned ID_WIDTH     = $clog2(NUM_REQ),
  localparam int unsigned LEN_WIDTH    = $clog2(LENGTH+1)
) (
  input  logic                               clk,
  input  logic                               rst,
  list_arbiter_if.slave                      bus,
  output logic                               busy,
  output logic [2:0]                         list_op_sel,
  output logic                               list_op_en,
  output logic [DATA_WIDTH-1:0]              list_data_in,
  output logic [LENGTH_WIDTH-1:0]            list_index_in,
  input  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] list_data_out,
  input  logic                               list_op_done,
  input  logic                               list_op_in_progress,
  input  logic                               list_op_error,
  input  logic [LEN_WIDTH-1:0]               list_len
);

  localparam logic [2:0] OpFindAll = 3'b010;
  localparam logic [2:0] OpFind1st = 3'b011;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                            state_q, state_d;
  logic [ID_WIDTH-1:0]               ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]               owner_q, owner_d;
  logic [NUM_REQ-1:0]                gnt_q, gnt_d;
  logic [NUM_REQ-1:0]                rsp_valid_q, rsp_valid_d;
  logic                              rsp_last_q, rsp_last_d;
  logic                              rsp_error_q, rsp_error_d;
  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                              busy_q, busy_d;
  logic                              op_en_q, op_en_d;
  logic [2:0]                        op_sel_q, op_sel_d;
  logic [DATA_WIDTH-1:0]             data_q, data_d;
  logic [LENGTH_WIDTH-1:0]           index_q, index_d;

  logic [2:0]              op_arr    [NUM_REQ];
  logic [DATA_WIDTH-1:0]   data_arr  [NUM_REQ];
  logic [LENGTH_WIDTH-1:0] index_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]    = bus.req_op_sel[3*g +: 3];
    assign data_arr[g]  = bus.req_data[DATA_WIDTH*g +: DATA_WIDTH];
    assign index_arr[g] = bus.req_index[LENGTH_WIDTH*g +: LENGTH_WIDTH];
  end

  // Round-robin pick: first asserted req at or after the pointer.
  logic                found;
  logic [ID_WIDTH-1:0] win;
  int unsigned         idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req[ID_WIDTH'(idx)]) begin
        found = 1'b1;
        win   = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_last_d  = 1'b0;
    rsp_error_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    op_en_d     = 1'b0;
    op_sel_d    = op_sel_q;
    data_d      = data_q;
    index_d     = index_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          ptr_d      = ID_WIDTH'((int'(win) + 1) % NUM_REQ);
          owner_d    = win;
          // Searches on an empty list are answered here without touching the list.
          if ((op_arr[win] == OpFindAll || op_arr[win] == OpFind1st) && list_len == '0) begin
            rsp_valid_d[win] = 1'b1;
            rsp_last_d       = 1'b1;
            rsp_error_d      = 1'b1;
            rsp_data_d       = '0;
          end else begin
            op_sel_d = op_arr[win];
            data_d   = data_arr[win];
            index_d  = index_arr[win];
            op_en_d  = 1'b1;
            busy_d   = 1'b1;
            state_d  = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (list_op_done) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = list_data_out;
          rsp_error_d          = list_op_error;
          if (!list_op_in_progress) begin
            rsp_last_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      op_en_q     <= 1'b0;
      op_sel_q    <= '0;
      data_q      <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      op_en_q     <= op_en_d;
      op_sel_q    <= op_sel_d;
      data_q      <= data_d;
      index_q     <= index_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;
  assign busy          = busy_q;
  assign list_op_sel   = op_sel_q;
  assign list_op_en    = op_en_q;
  assign list_data_in  = data_q;
  assign list_index_in = index_q;

endmodule

// File: tb/tb_list_arbiter.sv
// Directed bench for list_arbiter; the bench itself plays the list, answering
// op_en with hand-chosen done/in_progress/data_out beats.
module tb_list_arbiter;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LENGTH     = 8;
  localparam int unsigned LW         = $clog2(LENGTH);

  localparam logic [2:0] OP_READ     = 3'b000;
  localparam logic [2:0] OP_INSERT   = 3'b001;
  localparam logic [2:0] OP_FIND_ALL = 3'b010;
  localparam logic [2:0] OP_FIND_1ST = 3'b011;
  localparam logic [2:0] OP_SORT_ASC = 3'b101;

  logic                    clk;
  logic                    rst;
  logic                    busy;
  logic [2:0]              list_op_sel;
  logic                    list_op_en;
  logic [DATA_WIDTH-1:0]   list_data_in;
  logic [LW-1:0]           list_index_in;
  logic [LW+DATA_WIDTH-1:0] list_data_out;
  logic                    list_op_done;
  logic                    list_op_in_progress;
  logic                    list_op_error;
  logic [$clog2(LENGTH+1)-1:0] list_len;

  list_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .LENGTH(LENGTH)) bus ();

  list_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .LENGTH(LENGTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus.slave),
    .busy                (busy),
    .list_op_sel         (list_op_sel),
    .list_op_en          (list_op_en),
    .list_data_in        (list_data_in),
    .list_index_in       (list_index_in),
    .list_data_out       (list_data_out),
    .list_op_done        (list_op_done),
    .list_op_in_progress (list_op_in_progress),
    .list_op_error       (list_op_error),
    .list_len            (list_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [2:0] op, input logic [31:0] d,
                         input logic [LW-1:0] ix);
    bus.req_op_sel[3*r +: 3]                   = op;
    bus.req_data[DATA_WIDTH*r +: DATA_WIDTH]   = d;
    bus.req_index[LW*r +: LW]                  = ix;
  endtask

  task automatic list_beat(input logic done, input logic inprog, input logic [LW+DATA_WIDTH-1:0] d);
    list_op_done        = done;
    list_op_in_progress = inprog;
    list_data_out       = d;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.req_op_sel = '0; bus.req_data = '0; bus.req_index = '0;
    list_data_out = '0; list_op_done = 1'b0; list_op_in_progress = 1'b0;
    list_op_error = 1'b0; list_len = '0;
    tick(); tick();
    check("rst_gnt", bus.gnt, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_en", list_op_en, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    rst = 1'b0;

    // Single READ from requester 1
    list_len = 1;
    set_cmd(1, OP_READ, 32'h0, 3'd0);
    bus.req = 4'b0010;
    tick();
    check("rd_gnt", bus.gnt, 4'b0010);
    check("rd_op_en", list_op_en, 1);
    check("rd_busy", busy, 1);
    check("rd_op_sel", list_op_sel, OP_READ);
    bus.req = '0;
    tick();
    check("rd_op_en_pulse", list_op_en, 0);
    check("rd_gnt_pulse", bus.gnt, 0);
    list_beat(1'b1, 1'b0, 35'h55);
    tick();
    check("rd_rsp_valid", bus.rsp_valid, 4'b0010);
    check("rd_rsp_last", bus.rsp_last, 1);
    check("rd_rsp_data", bus.rsp_data, 35'h55);
    check("rd_rsp_error", bus.rsp_error, 0);
    check("rd_busy_end", busy, 0);
    list_beat(1'b0, 1'b0, 35'h55);
    tick();
    check("rd_rsp_single", bus.rsp_valid, 0);

    // Reset puts the pointer back at 0 (it sits at 2 now)
    rst = 1'b1; tick(); rst = 1'b0;

    // Fairness: all four insert at once
    for (int i = 0; i < 4; i++) set_cmd(i, OP_INSERT, 32'(10 + i), 3'd0);
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fair_gnt%0d", i), bus.gnt, 64'(1 << i));
      check($sformatf("fair_data%0d", i), list_data_in, 64'(10 + i));
      bus.req[i] = 1'b0;
      tick();
      list_beat(1'b1, 1'b0, '0);
      tick();
      check($sformatf("fair_rsp%0d", i), bus.rsp_valid, 64'(1 << i));
      check($sformatf("fair_space%0d", i), bus.gnt, 0);
      list_beat(1'b0, 1'b0, '0);
    end

    // FIND_ALL 7 by requester 3 on [7,3,7,7]
    list_len = 4;
    set_cmd(3, OP_FIND_ALL, 32'd7, 3'd0);
    bus.req = 4'b1000;
    tick();
    check("fa_gnt", bus.gnt, 4'b1000);
    check("fa_data_in", list_data_in, 7);
    bus.req = '0;
    tick();
    for (int h = 0; h < 3; h++) begin
      logic [LW+DATA_WIDTH-1:0] hit;
      hit = (h == 0) ? 35'd0 : (h == 1) ? 35'd2 : 35'd3;
      list_beat(1'b1, 1'b1, hit);
      tick();
      check($sformatf("fa_valid%0d", h), bus.rsp_valid, 4'b1000);
      check($sformatf("fa_last%0d", h), bus.rsp_last, 0);
      check($sformatf("fa_data%0d", h), bus.rsp_data, hit);
      list_beat(1'b0, 1'b1, hit);
      tick();
      check($sformatf("fa_gap%0d", h), bus.rsp_valid, 0);
    end
    list_beat(1'b1, 1'b0, 35'd3);
    tick();
    check("fa_final_valid", bus.rsp_valid, 4'b1000);
    check("fa_final_last", bus.rsp_last, 1);
    check("fa_final_busy", busy, 0);
    list_beat(1'b0, 1'b0, 35'd3);

    // Empty-list FIND_1ST is rejected on the grant edge
    list_len = 0;
    set_cmd(2, OP_FIND_1ST, 32'd9, 3'd0);
    bus.req = 4'b0100;
    tick();
    check("ef_gnt", bus.gnt, 4'b0100);
    check("ef_valid", bus.rsp_valid, 4'b0100);
    check("ef_last", bus.rsp_last, 1);
    check("ef_error", bus.rsp_error, 1);
    check("ef_data", bus.rsp_data, 0);
    check("ef_op_en", list_op_en, 0);
    check("ef_busy", busy, 0);
    bus.req = '0;
    tick();
    check("ef_op_en2", list_op_en, 0);
    check("ef_valid2", bus.rsp_valid, 0);

    // Hold: SORT_ASC by 0, payload toggled, req[3] waits for the final beat
    list_len = 4;
    set_cmd(0, OP_SORT_ASC, 32'hAAAA, 3'd0);
    set_cmd(3, OP_FIND_1ST, 32'd7, 3'd0);
    bus.req = 4'b0001;
    tick();
    check("hd_gnt", bus.gnt, 4'b0001);
    check("hd_data_in", list_data_in, 32'hAAAA);
    bus.req = 4'b1000;
    set_cmd(0, OP_READ, 32'hBBBB, 3'd5);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("hd_hold%0d", c), list_data_in, 32'hAAAA);
      check($sformatf("hd_nognt%0d", c), bus.gnt, 0);
    end
    check("hd_op_sel", list_op_sel, OP_SORT_ASC);
    list_beat(1'b1, 1'b0, '0);
    tick();
    check("hd_rsp", bus.rsp_valid, 4'b0001);
    check("hd_gnt_late", bus.gnt, 0);
    list_beat(1'b0, 1'b0, '0);
    tick();
    check("hd_gnt3", bus.gnt, 4'b1000);
    check("hd_data3", list_data_in, 7);
    bus.req = '0;
    tick();

    // Reset while FIND_1ST waits; a done during reset must not produce a beat
    list_beat(1'b1, 1'b0, 35'h123);
    rst = 1'b1;
    tick();
    check("mr_valid", bus.rsp_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_data_in", list_data_in, 0);
    check("mr_op_sel", list_op_sel, 0);
    check("mr_rsp_data", bus.rsp_data, 0);
    check("mr_last", bus.rsp_last, 0);
    rst = 1'b0;
    list_beat(1'b0, 1'b0, '0);

    set_cmd(0, OP_READ, 32'h0, 3'd2);
    bus.req = 4'b0101;
    tick();
    check("mr_gnt0", bus.gnt, 4'b0001);
    check("mr_index", list_index_in, 2);
    bus.req = '0;
    tick();
    list_beat(1'b1, 1'b0, 35'h77);
    tick();
    check("mr_rsp0", bus.rsp_valid, 4'b0001);
    check("mr_rsp_data0", bus.rsp_data, 35'h77);
    list_beat(1'b0, 1'b0, '0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
